cnt_sched: RTL and testbench

CNT_SCHED -- requirements
Module: cnt_sched

---
 rtl/cnt_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/cnt_sched.sv | 94 +++++++++
 tb/tb_cnt_sched.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// Shared defaults and helpers for the counter scheduler.
package cnt_sched_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int WIDTH_DEF  = 4;
  localparam int DEFVAL_DEF = 10;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select; the search starts at ptr_i.
module rr_arbiter
  import cnt_sched_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cnt_sched.sv
// Counter array sharing one adder, one add per cycle chosen round-robin.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int INITVAL = 0,
  parameter int DEFVAL  = DEFVAL_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] delta,
  input  logic [NREQ-1:0]       use_default,
  input  logic [NREQ-1:0]       clear,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ*WIDTH-1:0] cnt,
  output logic [NREQ-1:0]       wrap
);

  localparam int PW = ptr_w(NREQ);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INITVAL);
  localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(DEFVAL);

  logic [NREQ-1:0][WIDTH-1:0] cnt_q = {NREQ{INIT_W}};
  logic [NREQ-1:0][WIDTH-1:0] cnt_d;
  logic [NREQ-1:0][WIDTH-1:0] dlt_s;
  logic [NREQ-1:0]            wrap_q, wrap_d;
  logic [NREQ-1:0]            ack_q, ack_d;
  logic [PW-1:0]              ptr_q, ptr_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            win;
  logic [PW-1:0]   widx;
  logic [WIDTH-1:0] op;
  logic [WIDTH:0]   sum;

  assign dlt_s = delta;
  // A clearing requester never competes for the adder.
  assign elig  = req & ~clear;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .valid_o (win),
    .idx_o   (widx)
  );

  assign op  = use_default[widx] ? DEF_W : dlt_s[widx];
  assign sum = {1'b0, cnt_q[widx]} + {1'b0, op};

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    ack_d  = '0;
    ptr_d  = ptr_q;
    if (win) begin
      cnt_d[widx] = sum[WIDTH-1:0];
      if (sum[WIDTH]) wrap_d[widx] = 1'b1;
      ack_d = gnt;
      ptr_d = (widx == PW'(NREQ - 1)) ? '0 : widx + PW'(1);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (clear[i]) begin
        cnt_d[i]  = INIT_W;
        wrap_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= {NREQ{INIT_W}};
      wrap_q <= '0;
      ack_q  <= '0;
      ptr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ack_q  <= ack_d;
      ptr_q  <= ptr_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign ack  = ack_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed vector bench for cnt_sched, default and INITVAL=3 builds.
module tb_cnt_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, ud, clr;
  logic [15:0] dlt;
  logic [3:0]  ack, wrap, ack3, wrap3;
  logic [15:0] cnt, cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_sched dut (
    .clock       (clk),
    .reset       (rst),
    .req         (req),
    .delta       (dlt),
    .use_default (ud),
    .clear       (clr),
    .ack         (ack),
    .cnt         (cnt),
    .wrap        (wrap)
  );

  cnt_sched #(.INITVAL(3)) dut3 (
    .clock       (clk),
    .reset       (rst),
    .req         (req),
    .delta       (dlt),
    .use_default (ud),
    .clear       (clr),
    .ack         (ack3),
    .cnt         (cnt3),
    .wrap        (wrap3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ud;
    logic [3:0]  clr;
    logic [15:0] dlt;
    logic [3:0]  ack;
    logic [15:0] cnt;
    logic [3:0]  wrap;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] q, input logic [3:0] u,
    input logic [3:0] c, input logic [15:0] d,
    input logic [3:0] a, input logic [15:0] n, input logic [3:0] w);
    vec_t v;
    v.rst = r; v.req = q; v.ud = u; v.clr = c; v.dlt = d;
    v.ack = a; v.cnt = n; v.wrap = w;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q,
                       input logic [3:0] u, input logic [3:0] c,
                       input logic [15:0] d);
    @(negedge clk);
    rst = r; req = q; ud = u; clr = c; dlt = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; ud = '0; clr = '0; dlt = '0;

    // reset
    vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0000, 4'h0));
    // sole requester, default delta 10: 10, 4 (wrap), 14
    vt.push_back(mk(0, 4'h1, 4'h1, 4'h0, 16'h0000, 4'h1, 16'h000A, 4'h0));
    vt.push_back(mk(0, 4'h1, 4'h1, 4'h0, 16'h0000, 4'h1, 16'h0004, 4'h1));
    vt.push_back(mk(0, 4'h1, 4'h1, 4'h0, 16'h0000, 4'h1, 16'h000E, 4'h1));
    // clear alone drops count and wrap
    vt.push_back(mk(0, 4'h0, 4'h0, 4'h1, 16'h0000, 4'h0, 16'h0000, 4'h0));
    // reset to put ptr at 0, then full round-robin twice
    vt.push_back(mk(1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0000, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h1, 16'h0001, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h2, 16'h0011, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h4, 16'h0111, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h8, 16'h1111, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h1, 16'h1112, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h2, 16'h1122, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h4, 16'h1222, 4'h0));
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h8, 16'h2222, 4'h0));
    // cnt0 to 5, then a zero add on 3 wraps ptr back to 0
    vt.push_back(mk(0, 4'h1, 4'h0, 4'h0, 16'h0003, 4'h1, 16'h2225, 4'h0));
    vt.push_back(mk(0, 4'h8, 4'h0, 4'h0, 16'h0000, 4'h8, 16'h2225, 4'h0));
    // req0+clear0 at ptr 0: 0 cleared, 1 served in the same cycle
    vt.push_back(mk(0, 4'h3, 4'h0, 4'h1, 16'h0011, 4'h2, 16'h2230, 4'h0));
    // cnt1 to 15 then overflow; wrap1 is sticky
    vt.push_back(mk(0, 4'h2, 4'h0, 4'h0, 16'h00C0, 4'h2, 16'h22F0, 4'h0));
    vt.push_back(mk(0, 4'h2, 4'h0, 4'h0, 16'h0010, 4'h2, 16'h2200, 4'h2));
    vt.push_back(mk(0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h2200, 4'h2));
    // clear1 alongside an add on 2
    vt.push_back(mk(0, 4'h4, 4'h0, 4'h2, 16'h0100, 4'h4, 16'h2300, 4'h0));
    // two clears in parallel with an add on 0
    vt.push_back(mk(0, 4'h1, 4'h0, 4'hC, 16'h0002, 4'h1, 16'h0002, 4'h0));
    // reset while req2 would win: discarded, no ack
    vt.push_back(mk(1, 4'h4, 4'h0, 4'h0, 16'h0500, 4'h0, 16'h0000, 4'h0));
    // ptr is back at 0: requester 0 wins first
    vt.push_back(mk(0, 4'hF, 4'h0, 4'h0, 16'h1111, 4'h1, 16'h0001, 4'h0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].req, vt[i].ud, vt[i].clr, vt[i].dlt);
      chk("ack",  i, {12'h0, ack},  {12'h0, vt[i].ack});
      chk("cnt",  i, cnt,           vt[i].cnt);
      chk("wrap", i, {12'h0, wrap}, {12'h0, vt[i].wrap});
    end

    // INITVAL=3 build: reset value and clear reload
    drive(1, 4'h0, 4'h0, 4'h0, 16'h0000);
    chk("init3_reset", 100, cnt3, 16'h3333);
    drive(0, 4'h8, 4'h0, 4'h0, 16'h4000);
    chk("init3_add",   101, cnt3, 16'h7333);
    chk("init3_ack",   101, {12'h0, ack3}, 16'h0008);
    drive(0, 4'h0, 4'h0, 4'h8, 16'h0000);
    chk("init3_clear", 102, cnt3, 16'h3333);
    chk("init3_noack", 102, {12'h0, ack3}, 16'h0000);

    // sole requester with a held level: acked every cycle
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'h4, 4'h0, 4'h0, 16'h0100);
      chk("sole_ack", 200 + k, {12'h0, ack}, 16'h0004);
    end
    chk("sole_cnt", 203, cnt, 16'h0300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
